// File: rtl/fetch_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_branch_unit
// Description : Fetches the instruction at the current PC over a req/ack
//               handshake, resolves BR/BRZ/BRN branches with clamped
//               targets and issues a one-cycle advance pulse to the PC
//               block. Halts on a sequential step past LAST_ADDR and flags
//               a sticky error when the memory never acknowledges.
// Ports       : clk, fetch_reset_n (async, active-low), cpu_enable,
//               pc_in[15:0], zero_flag, neg_flag,
//               imem_req, imem_addr[15:0], imem_ack, imem_data[15:0],
//               pc_advance, jump_flag, next[15:0], instr_out[15:0],
//               instr_valid, halted, fetch_err
// Revision    : 1.0  initial release
// ============================================================================
module fetch_branch_unit #(
    parameter int LAST_ADDR   = 27,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        fetch_reset_n,
    input  logic        cpu_enable,
    input  logic [15:0] pc_in,
    input  logic        zero_flag,
    input  logic        neg_flag,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        pc_advance,
    output logic        jump_flag,
    output logic [15:0] next,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   C_TIMEOUT = CNT_W'(ACK_TIMEOUT);
    localparam logic [15:0]        C_LAST16  = 16'(LAST_ADDR);
    localparam logic signed [16:0] C_LAST17  = 17'(LAST_ADDR);

    localparam logic [3:0] C_OP_BR  = 4'hC;
    localparam logic [3:0] C_OP_BRZ = 4'hD;
    localparam logic [3:0] C_OP_BRN = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ISSUE = 3'd2,
        S_HALT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic [15:0]        addr_q, addr_d;
    logic               adv_q, adv_d;
    logic               jump_q, jump_d;
    logic [15:0]        next_q, next_d;
    logic [15:0]        instr_q, instr_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;

    // ------------------------------------------------------------------
    // Branch resolution on the held instruction
    // ------------------------------------------------------------------
    logic [3:0]         w_opcode;
    logic signed [16:0] w_off;
    logic signed [16:0] w_sum;
    logic [15:0]        w_target;
    logic               w_taken;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_opcode  = instr_q[15:12];
    assign w_off     = {{8{instr_q[8]}}, instr_q[8:0]};
    assign w_sum     = $signed({1'b0, addr_q}) + w_off;
    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        w_target = w_sum[15:0];
        if (w_sum < 17'sd0) begin
            w_target = 16'd0;
        end else if (w_sum > C_LAST17) begin
            w_target = C_LAST16;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            C_OP_BR:  w_taken = 1'b1;
            C_OP_BRZ: w_taken = zero_flag;
            C_OP_BRN: w_taken = neg_flag;
            default:  w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        adv_d    = 1'b0;       // pulses default low every cycle
        jump_d   = 1'b0;
        next_d   = next_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_enable) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // cpu_enable is deliberately not consulted: a fetch in flight
                // always runs to ack or timeout.
                if (imem_ack) begin
                    instr_d = imem_data;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                if (cpu_enable) begin
                    adv_d = 1'b1;
                    if (w_taken) begin
                        jump_d  = 1'b1;
                        next_d  = w_target;
                        state_d = S_IDLE;
                    end else begin
                        next_d  = addr_q + 16'd1;
                        // A sequential step off the last address ends the
                        // program; a taken branch there keeps running.
                        state_d = (addr_q == C_LAST16) ? S_HALT : S_IDLE;
                    end
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge fetch_reset_n) begin
        if (!fetch_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= 16'd0;
            adv_q    <= 1'b0;
            jump_q   <= 1'b0;
            next_q   <= 16'd0;
            instr_q  <= 16'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            adv_q    <= adv_d;
            jump_q   <= jump_d;
            next_q   <= next_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc_advance  = adv_q;
    assign instr_valid = adv_q;
    assign jump_flag   = jump_q;
    assign next        = next_q;
    assign instr_out   = instr_q;
    assign halted      = halted_q;
    assign fetch_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_branch_unit
// Description : Self-checking bench for fetch_branch_unit. Directed cases
//               with hand-computed results plus randomized fetches whose
//               expectations come from a transaction-level branch model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_branch_unit;

    localparam int LAST = 27;
    localparam int TMO  = 15;

    logic        clk;
    logic        fetch_reset_n;
    logic        cpu_enable;
    logic [15:0] pc_in;
    logic        zero_flag;
    logic        neg_flag;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        pc_advance;
    logic        jump_flag;
    logic [15:0] next;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic        fetch_err;

    fetch_branch_unit #(.LAST_ADDR(LAST), .ACK_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .fetch_reset_n(fetch_reset_n),
        .cpu_enable   (cpu_enable),
        .pc_in        (pc_in),
        .zero_flag    (zero_flag),
        .neg_flag     (neg_flag),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .pc_advance   (pc_advance),
        .jump_flag    (jump_flag),
        .next         (next),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Expectations consumed by the per-cycle monitor
    bit          mon_on     = 1'b0;
    bit          pulse_exp  = 1'b0;
    bit          exp_jump   = 1'b0;
    logic [15:0] exp_next   = 16'd0;
    logic [15:0] exp_instr  = 16'd0;
    bit          exp_halted = 1'b0;
    bit          exp_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch model: plain integer arithmetic on the instruction fields.
    task automatic model(input int addr, input logic [15:0] ins, input bit z, input bit n,
                         output bit j, output logic [15:0] nx);
        int       op;
        int       off;
        int       t;
        logic [8:0] f;
        op  = int'(ins[15:12]);
        f   = ins[8:0];
        off = f[8] ? int'(f) - 512 : int'(f);
        j   = (op == 12) || (op == 13 && z) || (op == 14 && n);
        t   = addr + off;
        if (t < 0) t = 0;
        else if (t > LAST) t = LAST;
        nx = j ? 16'(t) : 16'(addr + 1);
    endtask

    // Per-cycle compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid_vs_adv", {31'd0, instr_valid}, {31'd0, pc_advance});
            chk("pulse", {31'd0, pc_advance}, {31'd0, pulse_exp});
            if (pulse_exp) begin
                chk("jump_flag", {31'd0, jump_flag}, {31'd0, exp_jump});
                chk("next", {16'd0, next}, {16'd0, exp_next});
                chk("instr_at_pulse", {16'd0, instr_out}, {16'd0, exp_instr});
            end else begin
                chk("jump_idle", {31'd0, jump_flag}, 32'd0);
            end
            chk("halted", {31'd0, halted}, {31'd0, exp_halted});
            chk("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
        end
    end

    task automatic do_reset();
        fetch_reset_n = 1'b0;
        cpu_enable    = 1'b0;
        imem_ack      = 1'b0;
        pulse_exp     = 1'b0;
        exp_halted    = 1'b0;
        exp_err       = 1'b0;
        tick();
        tick();
        fetch_reset_n = 1'b1;
        tick();
    endtask

    // One complete fetch/issue transaction.
    task automatic fetch(input logic [15:0] pc, input logic [15:0] data, input bit z, input bit n,
                         input int ack_dly, input int en_gap, input bit ej, input logic [15:0] en);
        pc_in      = pc;
        zero_flag  = z;
        neg_flag   = n;
        cpu_enable = 1'b1;
        tick();
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("req_addr", {16'd0, imem_addr}, {16'd0, pc});
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", {16'd0, imem_addr}, {16'd0, pc});
        end
        imem_ack  = 1'b1;
        imem_data = data;
        if (en_gap > 0) cpu_enable = 1'b0;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        chk("req_drop", {31'd0, imem_req}, 32'd0);
        chk("instr_out", {16'd0, instr_out}, {16'd0, data});
        for (int i = 0; i < en_gap; i++) tick();
        cpu_enable = 1'b1;
        exp_jump   = ej;
        exp_next   = en;
        exp_instr  = data;
        tick();
        pulse_exp  = 1'b1;
        cpu_enable = 1'b0;
        tick();
        pulse_exp  = 1'b0;
        if (!ej && pc == 16'(LAST)) exp_halted = 1'b1;
        chk("next_held", {16'd0, next}, {16'd0, en});
        chk("jump_clear", {31'd0, jump_flag}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int          cnt;
        bit          j;
        logic [15:0] nx;
        logic [15:0] ins;
        int          pc;
        bit          z;
        bit          n;

        fetch_reset_n = 1'b0;
        cpu_enable    = 1'b0;
        pc_in         = 16'd0;
        zero_flag     = 1'b0;
        neg_flag      = 1'b0;
        imem_ack      = 1'b0;
        imem_data     = 16'd0;
        tick();
        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("rst_next", {16'd0, next}, 32'd0);
        chk("rst_instr", {16'd0, instr_out}, 32'd0);
        chk("rst_adv", {31'd0, pc_advance}, 32'd0);
        fetch_reset_n = 1'b1;
        mon_on = 1'b1;
        tick();

        // Directed cases with hand-computed expectations
        fetch(16'd0,  16'h1234, 0, 0, 0, 0, 1'b0, 16'd1);
        fetch(16'd5,  16'hC003, 0, 0, 0, 0, 1'b1, 16'd8);
        fetch(16'd5,  16'hC1FC, 0, 0, 1, 0, 1'b1, 16'd1);
        fetch(16'd20, 16'hC064, 0, 0, 0, 0, 1'b1, 16'd27);
        fetch(16'd2,  16'hC1F6, 0, 0, 2, 0, 1'b1, 16'd0);
        fetch(16'd4,  16'hD002, 0, 1, 0, 0, 1'b0, 16'd5);
        fetch(16'd4,  16'hD002, 1, 0, 0, 0, 1'b1, 16'd6);
        fetch(16'd7,  16'hE1FF, 0, 1, 0, 0, 1'b1, 16'd6);
        // cpu_enable dropped while the fetch is in flight
        fetch(16'd9,  16'h0042, 0, 0, 1, 3, 1'b0, 16'd10);
        // Taken branch at the last address keeps running
        fetch(16'd27, 16'hC1FE, 0, 0, 0, 0, 1'b1, 16'd25);

        // Randomized fetches against the model
        for (int k = 0; k < 40; k++) begin
            pc  = int'($urandom_range(0, LAST - 1));
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ins[15:12] = 4'hC;
                1: ins[15:12] = 4'hD;
                2: ins[15:12] = 4'hE;
                default: ;
            endcase
            z = 1'($urandom);
            n = 1'($urandom);
            model(pc, ins, z, n, j, nx);
            fetch(16'(pc), ins, z, n, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), j, nx);
        end

        // Sequential step at the last address halts
        fetch(16'd27, 16'h0123, 0, 0, 0, 0, 1'b0, 16'd28);
        cpu_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        end
        do_reset();
        chk("halt_cleared", {31'd0, halted}, 32'd0);

        // Ack timeout
        pc_in      = 16'd3;
        cpu_enable = 1'b1;
        cnt        = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (imem_req) cnt++;
            else if (cnt > 0) break;
        end
        exp_err = 1'b1;
        chk("req_high_cycles", 32'(cnt), 32'(TMO));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("err_no_req", {31'd0, imem_req}, 32'd0);
        end
        do_reset();

        // Mid-fetch asynchronous reset, then a late ack is ignored
        pc_in      = 16'd9;
        cpu_enable = 1'b1;
        tick();
        chk("mid_req_up", {31'd0, imem_req}, 32'd1);
        cpu_enable = 1'b0;
        #2;
        fetch_reset_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_req}, 32'd0);
        tick();
        fetch_reset_n = 1'b1;
        tick();
        imem_ack  = 1'b1;
        imem_data = 16'hABCD;
        tick();
        imem_ack  = 1'b0;
        tick();
        chk("late_ack_instr", {16'd0, instr_out}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
